// File: rtl/prod_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier product register.
package prod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold 0..w so the full step count is representable.
    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic int last_idx(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/prod_step_cnt.sv
// Step counter for the product register: synchronous clear, enable, terminal-count flag.
module prod_step_cnt
    import prod_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(last_idx(WIDTH));

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/prod_reg_seq.sv
// Product/multiplier register {guard, hi, lo} with step FSM for the shift-add multiplier.
// Optional overflow flag enabled by defining PROD_OVF_DETECT_EN.
module prod_reg_seq
    import prod_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               alu_cout,
    input  logic [WIDTH-1:0]   alu_result,
    output logic [WIDTH-1:0]   prod_hi,
    output logic               mulr_lsb,
    output logic               last_step,
    output logic               busy,
    output logic               done,
`ifdef PROD_OVF_DETECT_EN
    output logic               ovf,
`endif
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_guard;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_sm;
    logic             w_start_acc;
    logic             w_step;
    logic             w_cnt_last;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_nxt;

    prod_step_cnt #(
        .WIDTH (WIDTH)
    ) u_step_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_start_acc),
        .i_en    (w_step),
        .o_last  (w_cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accept the ALU sum when lo[0] is set, then shift right; signed mode replicates the guard.
    always_comb begin
        w_sum = r_lo[0] ? {alu_cout, alu_result} : {r_guard, r_hi};
        w_nxt = {(r_sm ? w_sum[WIDTH] : 1'b0), w_sum, r_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_sm    <= 1'b0;
        end else if (w_start_acc) begin
            r_guard <= 1'b0;
            r_hi    <= '0;
            r_lo    <= multiplier;
            r_sm    <= signed_mode;
        end else if (w_step) begin
            {r_guard, r_hi, r_lo} <= w_nxt;
        end
    end

    assign prod_hi   = r_hi;
    assign mulr_lsb  = r_lo[0];
    assign last_step = busy & w_cnt_last;
    assign product   = {r_hi, r_lo};

`ifdef PROD_OVF_DETECT_EN
    logic           r_ovf;
    logic           w_ovf_nxt;
    logic [WIDTH:0] w_top;

    // Judge overflow on the final-step next value so the flag rises with done.
    always_comb begin
        w_top     = w_nxt[2*WIDTH-1:WIDTH-1];
        w_ovf_nxt = r_sm ? ~((&w_top) | ~(|w_top)) : (|w_nxt[2*WIDTH-1:WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_start_acc) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_cnt_last) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_prod_reg_seq.sv
// Directed testbench for prod_reg_seq (W=8) with a behavioural add/sub ALU model.
module tb_prod_reg_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   multiplier = '0;
    logic           alu_cout;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   prod_hi;
    logic           mulr_lsb;
    logic           last_step;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
`ifdef PROD_OVF_DETECT_EN
    logic           ovf;
`endif

    logic [W-1:0]   mcand = '0;
    logic           tb_sm = 1'b0;
    logic [W:0]     alu_a;
    logic [W:0]     alu_b;
    logic [W:0]     alu_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prod_reg_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .multiplier  (multiplier),
        .alu_cout    (alu_cout),
        .alu_result  (alu_result),
        .prod_hi     (prod_hi),
        .mulr_lsb    (mulr_lsb),
        .last_step   (last_step),
        .busy        (busy),
        .done        (done),
`ifdef PROD_OVF_DETECT_EN
        .ovf         (ovf),
`endif
        .product     (product)
    );

    // External ALU: hi + mcand, or hi - mcand on the final signed step.
    always_comb begin
        alu_a = tb_sm ? {prod_hi[W-1], prod_hi} : {1'b0, prod_hi};
        alu_b = tb_sm ? {mcand[W-1], mcand} : {1'b0, mcand};
        alu_s = (tb_sm && last_step) ? (alu_a - alu_b) : (alu_a + alu_b);
        {alu_cout, alu_result} = alu_s;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a multiply in the current (IDLE) cycle and waits for done; returns done's cycle index.
    task automatic run_mul(input logic [W-1:0] mr, input logic [W-1:0] mc, input logic sm,
                           output logic [2*W-1:0] res, output int dcyc, output logic seen);
        tb_sm       = sm;
        mcand       = mc;
        multiplier  = mr;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start = 1'b0;
        dcyc  = 1;
        while (!done && dcyc < 30) begin
            tick();
            dcyc++;
        end
        seen = done;
        res  = product;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (last_step !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last_step); end
        checks++;
        if (product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product); end
`ifdef PROD_OVF_DETECT_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    endtask

    task automatic test_unsigned_basic();
        int cyc;
        start       = 1'b1;
        multiplier  = 8'd3;
        mcand       = 8'd5;
        tb_sm       = 1'b0;
        signed_mode = 1'b0;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_c1: got %b expected 1", busy); end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (busy !== 1'b1 || last_step !== 1'b1)
            begin errors++; $display("FAIL last_step_c8: got busy=%b last=%b expected 1 1", busy, last_step); end
        tick();
        cyc = 9;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL done_c%0d: got done=%b busy=%b expected 1 0", cyc, done, busy); end
        checks++;
        if (product !== 16'h000F) begin errors++; $display("FAIL u3x5: got %h expected 000F", product); end
        tick();
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
        checks++;
        if (product !== 16'h000F) begin errors++; $display("FAIL u3x5_hold: got %h expected 000F", product); end
    endtask

    task automatic test_products();
        logic [2*W-1:0] res;
        int dc;
        logic seen;
        logic [W-1:0]   mr_t [5] = '{8'hFD, 8'h80, 8'hFF, 8'h00, 8'h07};
        logic [W-1:0]   mc_t [5] = '{8'h05, 8'h80, 8'hFF, 8'h5A, 8'hFA};
        logic           sm_t [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2*W-1:0] ex_t [5] = '{16'hFFF1, 16'h4000, 16'hFE01, 16'h0000, 16'hFFD6};
        for (int k = 0; k < 5; k++) begin
            run_mul(mr_t[k], mc_t[k], sm_t[k], res, dc, seen);
            checks++;
            if (!seen || dc != 9)
                begin errors++; $display("FAIL prod%0d_timing: got done at %0d expected 9", k, dc); end
            checks++;
            if (res !== ex_t[k])
                begin errors++; $display("FAIL prod%0d: got %h expected %h", k, res, ex_t[k]); end
            tick();
        end
    endtask

    task automatic test_start_midrun();
        int cyc;
        multiplier  = 8'd3;
        mcand       = 8'd5;
        tb_sm       = 1'b0;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start       = 1'b1;
        multiplier  = 8'h77;
        signed_mode = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 5;
        while (!done && cyc < 30) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != 9) begin errors++; $display("FAIL midrun_timing: got done at %0d expected 9", cyc); end
        checks++;
        if (product !== 16'h000F) begin errors++; $display("FAIL midrun_product: got %h expected 000F", product); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrun_no_restart: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_midrun();
        logic [2*W-1:0] res;
        int dc;
        logic seen;
        logic saw_done;
        multiplier  = 8'hFF;
        mcand       = 8'hFF;
        tb_sm       = 1'b0;
        signed_mode = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++;
        if (product !== 16'h0000) begin errors++; $display("FAIL rst_mid_product: got %h expected 0000", product); end
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got activity=%b expected 0", saw_done); end
        run_mul(8'd3, 8'd5, 1'b0, res, dc, seen);
        checks++;
        if (!seen || dc != 9 || res !== 16'h000F)
            begin errors++; $display("FAIL rst_mid_rerun: got %h at %0d expected 000F at 9", res, dc); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] res;
        int dc;
        logic seen;
        run_mul(8'd12, 8'd11, 1'b0, res, dc, seen);
        checks++;
        if (!seen || res !== 16'h0084) begin errors++; $display("FAIL b2b_first: got %h expected 0084", res); end
        tick();
        run_mul(8'hFE, 8'h03, 1'b1, res, dc, seen);
        checks++;
        if (!seen || dc != 9 || res !== 16'hFFFA)
            begin errors++; $display("FAIL b2b_second: got %h at %0d expected FFFA at 9", res, dc); end
        tick();
    endtask

`ifdef PROD_OVF_DETECT_EN
    task automatic test_ovf();
        logic [2*W-1:0] res;
        int dc;
        logic seen;
        run_mul(8'd16, 8'd8, 1'b1, res, dc, seen);
        checks++;
        if (res !== 16'h0080 || ovf !== 1'b1)
            begin errors++; $display("FAIL ovf_s16x8: got %h ovf=%b expected 0080 1", res, ovf); end
        tick();
        tick();
        tick();
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", ovf); end
        start       = 1'b1;
        multiplier  = 8'd4;
        mcand       = 8'd4;
        tb_sm       = 1'b1;
        signed_mode = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start: got %b expected 0", ovf); end
        dc = 1;
        while (!done && dc < 30) begin
            tick();
            dc++;
        end
        checks++;
        if (product !== 16'h0010 || ovf !== 1'b0)
            begin errors++; $display("FAIL ovf_s4x4: got %h ovf=%b expected 0010 0", product, ovf); end
        tick();
        run_mul(8'hFF, 8'hFF, 1'b0, res, dc, seen);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_u255x255: got %b expected 1", ovf); end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        tick();
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_unsigned_basic();
        test_products();
        test_start_midrun();
        test_reset_midrun();
        test_back_to_back();
`ifdef PROD_OVF_DETECT_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
